// File: rtl/eth_axis_fcs_inserter_128b_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_axis_fcs_inserter_128b_if
// Description : 128-bit AXI4-Stream bundle (tvalid/tready/tdata/tkeep/tlast)
//               used on both sides of the Ethernet FCS inserter.
// Revision    : 1.0 - initial release
// ============================================================================
interface eth_axis_fcs_inserter_128b_if;
  logic         tvalid;
  logic         tready;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tlast;

  // Source side of the stream
  modport master (
    output tvalid,
    output tdata,
    output tkeep,
    output tlast,
    input  tready
  );

  // Sink side of the stream
  modport slave (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tlast,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/eth_axis_fcs_inserter_128b.sv
`default_nettype none
// ============================================================================
// Module      : eth_axis_fcs_inserter_128b
// Description : Appends the Ethernet CRC-32 FCS to 128-bit AXI-Stream frames,
//               optionally zero-padding short frames to the minimum length.
//               One registered output stage; the FCS either fits into the
//               last beat or spills into one trailing beat.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_axis_fcs_inserter_128b #(
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64
) (
  input  wire                          clk,
  input  wire                          rst,
  eth_axis_fcs_inserter_128b_if.slave  s_axis,
  eth_axis_fcs_inserter_128b_if.master m_axis
);

  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  // Pad target excludes the 4 FCS bytes
  localparam int          PAD_TARGET_I = MIN_FRAME_LENGTH - 4;
  localparam bit          PAD_EN       = (ENABLE_PADDING != 0) && (PAD_TARGET_I > 0);
  localparam logic [16:0] PAD_TARGET   = (PAD_TARGET_I > 0) ? 17'(PAD_TARGET_I) : 17'd0;

  typedef enum logic [1:0] {
    ST_DATA  = 2'd0,
    ST_PAD   = 2'd1,
    ST_EXTRA = 2'd2
  } state_t;

  // Byte-serial reflected CRC-32 over the first nbytes bytes of a beat
  function automatic logic [31:0] crc_update(input logic [31:0]  crc_in,
                                             input logic [127:0] data,
                                             input logic [4:0]   nbytes);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < nbytes) begin
        c = c ^ {24'd0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  // Contiguous keep mask with n low bits set (n = 0..16)
  function automatic logic [15:0] keep_mask(input logic [4:0] n);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      m[i] = (5'(i) < n);
    end
    return m;
  endfunction

  // Registered state
  state_t        state, state_nxt;
  logic [31:0]   crc, crc_nxt;
  logic [15:0]   byte_cnt, cnt_nxt;
  logic [31:0]   extra_data, extra_data_nxt;
  logic [2:0]    extra_len, extra_len_nxt;
  logic          out_valid, out_valid_nxt;
  logic [127:0]  out_data, out_data_nxt;
  logic [15:0]   out_keep, out_keep_nxt;
  logic          out_last, out_last_nxt;
  logic          rdy_en;

  // Combinational helpers
  logic          out_ready;
  logic          s_ready;
  logic          in_fire;
  logic [4:0]    in_len;
  logic [127:0]  in_data;
  logic          beat_go;
  logic          beat_end;
  logic          to_pad;
  logic [127:0]  beat_payload;
  logic [4:0]    beat_len;
  logic [16:0]   frame_total;
  logic [16:0]   pad_left;
  logic [31:0]   crc_beat;
  logic [159:0]  fcs_wide;
  logic [159:0]  beat_wide;
  logic [16:0]   cnt_sum;

  // Output register may be reloaded when empty or being drained this cycle
  assign out_ready = !out_valid || m_axis.tready;
  // Input is accepted only in DATA, after the post-reset enable, with room downstream
  assign s_ready   = rdy_en && out_ready && (state == ST_DATA);
  assign in_fire   = s_axis.tvalid && s_ready;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = out_keep;
  assign m_axis.tlast  = out_last;

  // Input byte count and zero-masking of bytes not flagged by tkeep
  always_comb begin
    in_len  = '0;
    in_data = '0;
    for (int i = 0; i < 16; i++) begin
      if (s_axis.tkeep[i]) begin
        in_len             = 5'(i + 1);
        in_data[8*i +: 8]  = s_axis.tdata[8*i +: 8];
      end
    end
  end

  // Next-state, CRC/count update and output beat formation
  always_comb begin
    state_nxt      = state;
    crc_nxt        = crc;
    cnt_nxt        = byte_cnt;
    extra_data_nxt = extra_data;
    extra_len_nxt  = extra_len;
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    out_keep_nxt   = out_keep;
    out_last_nxt   = out_last;
    beat_go        = 1'b0;
    beat_end       = 1'b0;
    to_pad         = 1'b0;
    beat_payload   = '0;
    beat_len       = '0;
    frame_total    = '0;
    pad_left       = '0;

    unique case (state)
      ST_DATA: begin
        if (in_fire) begin
          beat_go      = 1'b1;
          beat_payload = in_data;
          beat_len     = in_len;
          if (s_axis.tlast) begin
            frame_total = {1'b0, byte_cnt} + {12'd0, in_len};
            if (PAD_EN && (frame_total < PAD_TARGET)) begin
              // Pad target reachable within this beat: finish here
              if (({1'b0, byte_cnt} + 17'd16) >= PAD_TARGET) begin
                beat_len = 5'(PAD_TARGET - {1'b0, byte_cnt});
                beat_end = 1'b1;
              end else begin
                beat_len = 5'd16;
                to_pad   = 1'b1;
              end
            end else begin
              beat_end = 1'b1;
            end
          end
        end else if (out_ready) begin
          out_valid_nxt = 1'b0;
        end
      end

      ST_PAD: begin
        if (out_ready) begin
          beat_go  = 1'b1;
          pad_left = PAD_TARGET - {1'b0, byte_cnt};
          if (pad_left <= 17'd16) begin
            beat_len = 5'(pad_left);
            beat_end = 1'b1;
          end else begin
            beat_len = 5'd16;
          end
        end
      end

      ST_EXTRA: begin
        if (out_ready) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = {96'd0, extra_data};
          out_keep_nxt  = keep_mask({2'b00, extra_len});
          out_last_nxt  = 1'b1;
          state_nxt     = ST_DATA;
        end
      end

      default: begin
        state_nxt = ST_DATA;
      end
    endcase

    // FCS bytes land directly after the last data/pad byte; overflow past
    // byte 15 ends up in bits [159:128] and forms the trailing beat.
    crc_beat  = crc_update(crc, beat_payload, beat_len);
    fcs_wide  = {128'd0, ~crc_beat} << {beat_len, 3'b000};
    beat_wide = {32'd0, beat_payload} | fcs_wide;
    cnt_sum   = {1'b0, byte_cnt} + {12'd0, beat_len};

    if (beat_go) begin
      out_valid_nxt = 1'b1;
      if (beat_end) begin
        crc_nxt      = CRC_INIT;
        cnt_nxt      = '0;
        out_data_nxt = beat_wide[127:0];
        if (beat_len <= 5'd12) begin
          out_keep_nxt = keep_mask(beat_len + 5'd4);
          out_last_nxt = 1'b1;
          state_nxt    = ST_DATA;
        end else begin
          out_keep_nxt   = 16'hFFFF;
          out_last_nxt   = 1'b0;
          extra_data_nxt = beat_wide[159:128];
          extra_len_nxt  = 3'(beat_len - 5'd12);
          state_nxt      = ST_EXTRA;
        end
      end else begin
        crc_nxt      = crc_beat;
        cnt_nxt      = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        out_data_nxt = beat_payload;
        out_keep_nxt = keep_mask(beat_len);
        out_last_nxt = 1'b0;
        if (to_pad) begin
          state_nxt = ST_PAD;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_DATA;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers: CRC accumulator, byte counter, trailing FCS, output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc        <= CRC_INIT;
      byte_cnt   <= '0;
      extra_data <= '0;
      extra_len  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      rdy_en     <= 1'b0;
    end else begin
      crc        <= crc_nxt;
      byte_cnt   <= cnt_nxt;
      extra_data <= extra_data_nxt;
      extra_len  <= extra_len_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      out_keep   <= out_keep_nxt;
      out_last   <= out_last_nxt;
      rdy_en     <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_axis_fcs_inserter_128b.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_axis_fcs_inserter_128b
// Description : Bench for the FCS inserter; one instance without padding
//               (index 0) and one with default padding (index 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_axis_fcs_inserter_128b;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t q0[$];
  beat_t q1[$];

  logic         drv_valid [2];
  logic [127:0] drv_data  [2];
  logic [15:0]  drv_keep  [2];
  logic         drv_last  [2];
  logic         out_rdy   [2] = '{1'b1, 1'b1};
  logic         rand_en   [2] = '{1'b0, 1'b0};
  logic         s_rdy     [2];
  logic         m_vld     [2];
  logic [127:0] m_dat     [2];
  logic [15:0]  m_kp      [2];
  logic         m_lst     [2];
  logic         prev_stall[2] = '{1'b0, 1'b0};
  beat_t        held      [2];

  eth_axis_fcs_inserter_128b_if s_np ();
  eth_axis_fcs_inserter_128b_if m_np ();
  eth_axis_fcs_inserter_128b_if s_p ();
  eth_axis_fcs_inserter_128b_if m_p ();

  eth_axis_fcs_inserter_128b #(.ENABLE_PADDING(0), .MIN_FRAME_LENGTH(64)) dut_np (
    .clk(clk), .rst(rst), .s_axis(s_np), .m_axis(m_np));
  eth_axis_fcs_inserter_128b #(.ENABLE_PADDING(1), .MIN_FRAME_LENGTH(64)) dut_p (
    .clk(clk), .rst(rst), .s_axis(s_p), .m_axis(m_p));

  assign s_np.tvalid = drv_valid[0];
  assign s_np.tdata  = drv_data[0];
  assign s_np.tkeep  = drv_keep[0];
  assign s_np.tlast  = drv_last[0];
  assign m_np.tready = out_rdy[0];
  assign s_p.tvalid  = drv_valid[1];
  assign s_p.tdata   = drv_data[1];
  assign s_p.tkeep   = drv_keep[1];
  assign s_p.tlast   = drv_last[1];
  assign m_p.tready  = out_rdy[1];

  assign s_rdy[0] = s_np.tready;
  assign s_rdy[1] = s_p.tready;
  assign m_vld[0] = m_np.tvalid;
  assign m_vld[1] = m_p.tvalid;
  assign m_dat[0] = m_np.tdata;
  assign m_dat[1] = m_p.tdata;
  assign m_kp[0]  = m_np.tkeep;
  assign m_kp[1]  = m_p.tkeep;
  assign m_lst[0] = m_np.tlast;
  assign m_lst[1] = m_p.tlast;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'(seed * 37 + i * 11 + (i >> 7));
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Golden model: byte stream with optional zero pad to 60, FCS LSB first, cut into 16-byte beats
  task automatic expect_frame(input int sel, input int len, input int seed, input bit pad);
    int total;
    int pos;
    logic [31:0] c;
    logic [7:0] b;
    beat_t bt;
    total = (pad && len < 60) ? 60 : len;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < total; i++) c = crc_byte(c, (i < len) ? pat(seed, i) : 8'h00);
    c = ~c;
    bt = '0;
    pos = 0;
    for (int i = 0; i < total + 4; i++) begin
      if (i < total) b = (i < len) ? pat(seed, i) : 8'h00;
      else b = c[8*(i-total) +: 8];
      bt.data[8*pos +: 8] = b;
      bt.keep[pos] = 1'b1;
      pos++;
      if (pos == 16 || i == total + 3) begin
        bt.last = (i == total + 3);
        if (sel == 0) q0.push_back(bt); else q1.push_back(bt);
        bt = '0;
        pos = 0;
      end
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance
  task automatic send_beat(input int sel, input logic [127:0] d, input logic [15:0] k,
                           input logic l, output int waits);
    drv_valid[sel] = 1'b1;
    drv_data[sel]  = d;
    drv_keep[sel]  = k;
    drv_last[sel]  = l;
    waits = 0;
    #1;
    while (!s_rdy[sel] && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    checks++;
    assert (waits < 100) else begin
      errors++;
      $error("FAIL accept_timeout dut%0d: observed waits %0d expected <100", sel, waits);
    end
    if (waits < 100) @(posedge clk);
    @(negedge clk);
    drv_valid[sel] = 1'b0;
  endtask

  task automatic send_frame(input int sel, input int len, input int seed, output int waits);
    logic [127:0] d;
    logic [15:0] k;
    int w;
    int nb;
    waits = 0;
    for (int base = 0; base < len; base += 16) begin
      d = '0;
      k = '0;
      nb = (len - base) < 16 ? (len - base) : 16;
      for (int j = 0; j < nb; j++) begin
        d[8*j +: 8] = pat(seed, base + j);
        k[j] = 1'b1;
      end
      send_beat(sel, d, k, (base + 16 >= len), w);
      waits += w;
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (q0.size() == 0 && q1.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed pending %0d/%0d expected 0/0", q0.size(), q1.size());
    end
  endtask

  task automatic mon_step(input int sel);
    beat_t obs;
    beat_t e;
    logic v;
    logic r;
    int qn;
    v = m_vld[sel];
    r = out_rdy[sel];
    obs.data = m_dat[sel];
    obs.keep = m_kp[sel];
    obs.last = m_lst[sel];
    if (rst) begin
      prev_stall[sel] = 1'b0;
      return;
    end
    if (prev_stall[sel]) begin
      check($sformatf("stall_valid%0d", sel), 128'(v), 128'd1);
      check($sformatf("stall_data%0d", sel), obs.data, held[sel].data);
      check($sformatf("stall_keep%0d", sel), 128'(obs.keep), 128'(held[sel].keep));
      check($sformatf("stall_last%0d", sel), 128'(obs.last), 128'(held[sel].last));
    end
    if (v && r) begin
      qn = (sel == 0) ? q0.size() : q1.size();
      check($sformatf("beat_expected%0d", sel), 128'(qn != 0), 128'd1);
      if (qn != 0) begin
        if (sel == 0) e = q0.pop_front(); else e = q1.pop_front();
        check($sformatf("out_data%0d", sel), obs.data, e.data);
        check($sformatf("out_keep%0d", sel), 128'(obs.keep), 128'(e.keep));
        check($sformatf("out_last%0d", sel), 128'(obs.last), 128'(e.last));
      end
    end
    held[sel] = obs;
    prev_stall[sel] = v && !r;
  endtask

  // Output monitor/scoreboard, sampled well after the falling edge
  always begin
    @(negedge clk);
    #2;
    mon_step(0);
    mon_step(1);
  end

  // Downstream ready: random when enabled, otherwise always ready
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) out_rdy[i] = rand_en[i] ? ($urandom_range(0, 99) < 55) : 1'b1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int wsum;
    beat_t b;
    logic [127:0] d;
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0;
      drv_data[i]  = '0;
      drv_keep[i]  = '0;
      drv_last[i]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_m_tvalid", 128'(m_vld[i]), 128'd0);
      check("rst_m_tlast",  128'(m_lst[i]), 128'd0);
      check("rst_m_tkeep",  128'(m_kp[i]),  128'd0);
      check("rst_m_tdata",  m_dat[i],       128'd0);
      check("rst_s_tready", 128'(s_rdy[i]), 128'd0);
    end
    rst = 1'b0;
    #1;
    check("tready_before_edge", 128'(s_rdy[0]), 128'd0);
    @(posedge clk);
    #1;
    check("tready_after_edge0", 128'(s_rdy[0]), 128'd1);
    check("tready_after_edge1", 128'(s_rdy[1]), 128'd1);
    @(negedge clk);

    // "123456789" without padding: FCS CB F4 39 26 sent as 26 39 F4 CB
    b.data = 128'h000000CBF43926393837363534333231;
    b.keep = 16'h1FFF;
    b.last = 1'b1;
    q0.push_back(b);
    d = 128'h00000000000000393837363534333231;
    send_beat(0, d, 16'h01FF, 1'b1, w);

    // 32-byte frame: FCS spills into a trailing 4-byte beat; no input bubble
    expect_frame(0, 32, 5, 1'b0);
    send_frame(0, 32, 5, w);
    #1;
    check("tready_in_extra", 128'(s_rdy[0]), 128'd0);
    check("stream_waits_32", 128'(w), 128'd0);
    @(negedge clk);
    drain(50);

    // Back-to-back frames whose FCS fits in the last beat: no idle cycles
    expect_frame(0, 9, 21, 1'b0);
    expect_frame(0, 12, 22, 1'b0);
    expect_frame(0, 1, 23, 1'b0);
    wsum = 0;
    send_frame(0, 9, 21, w);  wsum += w;
    send_frame(0, 12, 22, w); wsum += w;
    send_frame(0, 1, 23, w);  wsum += w;
    check("b2b_waits", 128'(wsum), 128'd0);

    // Spill boundaries: 13 and 16 bytes in the last beat
    expect_frame(0, 13, 31, 1'b0);
    send_frame(0, 13, 31, w);
    expect_frame(0, 16, 32, 1'b0);
    send_frame(0, 16, 32, w);
    drain(50);

    // Padded 14-byte frame: four beats, zero pad, FCS over 60 bytes
    expect_frame(1, 14, 9, 1'b1);
    send_frame(1, 14, 9, w);
    #1;
    check("tready_in_pad", 128'(s_rdy[1]), 128'd0);
    @(negedge clk);
    // Padding boundaries
    expect_frame(1, 59, 41, 1'b1);
    send_frame(1, 59, 41, w);
    expect_frame(1, 60, 42, 1'b1);
    send_frame(1, 60, 42, w);
    expect_frame(1, 61, 43, 1'b1);
    send_frame(1, 61, 43, w);
    expect_frame(1, 49, 44, 1'b1);
    send_frame(1, 49, 44, w);
    expect_frame(1, 33, 45, 1'b1);
    send_frame(1, 33, 45, w);
    drain(100);

    // Random downstream backpressure over three back-to-back frames
    rand_en[1] = 1'b1;
    expect_frame(1, 13, 51, 1'b1);
    expect_frame(1, 60, 52, 1'b1);
    expect_frame(1, 77, 53, 1'b1);
    send_frame(1, 13, 51, w);
    send_frame(1, 60, 52, w);
    send_frame(1, 77, 53, w);
    drain(400);
    rand_en[1] = 1'b0;
    @(negedge clk);

    // Byte counter must saturate: a 65540-byte frame ending with 4 bytes is not padded
    expect_frame(1, 65540, 61, 1'b1);
    send_frame(1, 65540, 61, w);
    check("stream_waits_long", 128'(w), 128'd0);
    drain(50);

    // Reset on beat 2 of a 5-beat frame; only the following 9-byte frame may appear
    d = {16{8'hA5}};
    send_beat(0, d, 16'hFFFF, 1'b0, w);
    drv_valid[0] = 1'b1;
    drv_data[0]  = {16{8'h5A}};
    drv_keep[0]  = 16'hFFFF;
    drv_last[0]  = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 128'(m_vld[0]), 128'd0);
    drv_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_frame(0, 9, 71, 1'b0);
    send_frame(0, 9, 71, w);
    drain(50);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
